muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file: it consumes the RsData/RtData operand pair read in decode and holds results in architectural HI/LO registers.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read Hi/Lo combinationally from the outputs.
- The pipeline stalls on Busy.

Parameters:
WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
Clock  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request new operation; sampled only while idle
Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
RsData  in  32  operand A / dividend / MTHI-MTLO write data
RtData  in  32  operand B / divisor
HiWe  in  1  MTHI: Hi <= RsData
LoWe  in  1  MTLO: Lo <= RsData
Hi  out  32  HI register
Lo  out  32  LO register
Busy  out  1  operation in progress
Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high):
  - Hi=0, Lo=0, Busy=0, Done=0.
  - State IDLE, iteration counter 0.
  - Any in-flight operation is discarded; Hi/Lo are not partially updated.
- States: IDLE, ITER, FIN.
- Busy is the registered value of (state != IDLE).
- IDLE:
  - On an edge with Start=1 (edge E0):
    - latch Op;
    - latch magnitudes of RsData/RtData (signed ops take the absolute value);
    - latch result sign bits;
    - clear the accumulator and counter;
    - go to ITER.
  - Otherwise HiWe/LoWe write Hi/Lo from RsData at the edge. Both may be asserted together.
  - Start has priority: HiWe/LoWe asserted on the Start edge are ignored.
- ITER:
  - One radix-2 step per edge, E1..E32, counter 0..31.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
  - At counter==31, go to FIN.
- FIN, at edge E33:
  - Apply signs.
  - Write Hi/Lo.
  - Pulse Done high for exactly the cycle E33..E34.
  - Return to IDLE.
- Latency: Busy is high from E0 to E33 (33 cycles). New Hi/Lo are visible after E33. A new Start is accepted at E33 at the earliest? No: the earliest next accept is E34, since Start is only sampled in IDLE.
- Start, HiWe and LoWe are ignored while Busy. Inputs need not be held after E0.
- Multiply results:
  - Hi = product[63:32], Lo = product[31:0].
  - Signed product = two's-complement negate of the 64-bit magnitude when the operand signs differ.
- Divide results:
  - Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero: negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0, any signedness: normal 33-cycle latency; result Lo=32'hFFFFFFFF, Hi=RsData as latched (original signed value).
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000 (wraps, no trap).
- MULTU/DIVU treat operands as unsigned; no sign correction is applied.
- Done never asserts without a preceding Start acceptance.
- Reset asserted mid-ITER/FIN suppresses Done.

Test Plan:
1. Reset, then MULTU Rs=0xFFFFFFFF Rt=0xFFFFFFFF -> Busy high 33 cycles, Done pulse after E33, Hi=0xFFFFFFFE, Lo=0x00000001.
2. MULT Rs=-3 (0xFFFFFFFD) Rt=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0.
3. DIVU 100/7 -> Lo=14, Hi=2. DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 7/-2 -> Lo=0xFFFFFFFD, Hi=1. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
4. DIV 0x12345678/0 -> Lo=0xFFFFFFFF, Hi=0x12345678, Done at the normal latency.
5. Assert HiWe with RsData=0xAAAA0000 and LoWe with 0x5555 while Busy, plus a second Start while Busy -> all ignored; the original result lands. In IDLE, the same writes -> Hi=0xAAAA0000, Lo=0x5555 next edge.
6. Start MULTU 5x6, assert Reset at E10 -> immediately Hi=Lo=0, Busy=0, no Done pulse. After Reset release, MULTU 5x6 -> Lo=30, Hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add for MULT/MULTU, restoring
// shift-subtract for DIV/DIVU. Signed operations run on magnitudes and
// the result signs are applied in the final cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] RsData,
   input  logic [WIDTH-1:0] RtData,
   input  logic             HiWe,
   input  logic             LoWe,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

   state_t                 state_q,   state_d;
   logic [CW-1:0]          cnt_q,     cnt_d;
   logic                   is_div_q,  is_div_d;
   logic                   neg_q,     neg_d;      // product / quotient negate
   logic                   rem_neg_q, rem_neg_d;  // remainder negate (dividend sign)
   logic                   div0_q,    div0_d;
   logic [WIDTH-1:0]       a_q,       a_d;        // multiplier / dividend-then-quotient
   logic [WIDTH-1:0]       b_q,       b_d;        // multiplicand / divisor magnitude
   logic [WIDTH-1:0]       rs_q,      rs_d;       // raw dividend for divide-by-zero
   logic [2*WIDTH-1:0]     acc_q,     acc_d;      // product, or remainder in low half
   logic [WIDTH-1:0]       hi_q,      hi_d;
   logic [WIDTH-1:0]       lo_q,      lo_d;
   logic                   busy_q;
   logic                   done_q;

   // Operand preparation for the accept edge
   logic             signed_op, rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;

   // One iteration step and final sign correction
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]     rem_shift;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_new;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quot_res, rem_res;

   // Datapath: magnitudes, single radix-2 step, signed final results
   always_comb begin
      signed_op = ~Op[0];
      rs_neg    = signed_op & RsData[WIDTH-1];
      rt_neg    = signed_op & RtData[WIDTH-1];
      rs_mag    = rs_neg ? -RsData : RsData;
      rt_mag    = rt_neg ? -RtData : RtData;

      mul_step  = {acc_q[2*WIDTH-2:0], 1'b0} + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);

      rem_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, b_q});
      rem_new   = rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];

      prod_res  = neg_q     ? -acc_q : acc_q;
      quot_res  = neg_q     ? -a_q : a_q;
      rem_res   = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   end

   // Next-state and register-update logic for the control FSM
   always_comb begin
      // NOTE: every _d defaults to its _q so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      a_d       = a_q;
      b_d       = b_q;
      rs_d      = rs_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               // Start wins over HiWe/LoWe on the same edge.
               state_d   = S_ITER;
               cnt_d     = '0;
               acc_d     = '0;
               is_div_d  = Op[1];
               neg_d     = rs_neg ^ rt_neg;
               rem_neg_d = rs_neg;
               div0_d    = (RtData == '0);
               a_d       = rs_mag;
               b_d       = rt_mag;
               rs_d      = RsData;
            end else begin
               if (HiWe) hi_d = RsData;
               if (LoWe) lo_d = RsData;
            end
         end
         S_ITER: begin
            if (is_div_q) begin
               acc_d = {{WIDTH{1'b0}}, rem_new};
               a_d   = {a_q[WIDTH-2:0], rem_ge};
            end else begin
               acc_d = mul_step;
               a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIN;
         end
         S_FIN: begin
            if (!is_div_q) begin
               hi_d = prod_res[2*WIDTH-1:WIDTH];
               lo_d = prod_res[WIDTH-1:0];
            end else if (div0_q) begin
               hi_d = rs_q;
               lo_d = '1;
            end else begin
               hi_d = rem_res;
               lo_d = quot_res;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight operation
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         rs_q      <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rs_q      <= rs_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_q == S_FIN);
      end
   end

   assign Hi   = hi_q;
   assign Lo   = lo_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// corner sequences (MTHI/MTLO, ignored inputs while busy, mid-op reset) and
// randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs, rt;
   logic        hi_we, lo_we;
   logic [31:0] hi, lo;
   logic        busy, done;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .Clock (clk),
      .Reset (rst),
      .Start (start),
      .Op    (op),
      .RsData(rs),
      .RtData(rt),
      .HiWe  (hi_we),
      .LoWe  (lo_we),
      .Hi    (hi),
      .Lo    (lo),
      .Busy  (busy),
      .Done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: straight 64-bit arithmetic on the architectural operands.
   function automatic void model(input logic [1:0] m_op, input logic [31:0] a32, input logic [31:0] b32,
                                 output logic [31:0] m_hi, output logic [31:0] m_lo);
      longint a, b, p, q, r;
      if (m_op[0]) begin
         a = {32'b0, a32};
         b = {32'b0, b32};
      end else begin
         a = $signed(a32);
         b = $signed(b32);
      end
      if (!m_op[1]) begin
         p    = a * b;
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (b32 == 32'd0) begin
         m_hi = a32;
         m_lo = 32'hFFFF_FFFF;
      end else begin
         q    = a / b;
         r    = a % b;
         m_hi = r[31:0];
         m_lo = q[31:0];
      end
   endfunction

   // Issue one operation and follow it to Done. With inject set, Start,
   // HiWe and LoWe are pulsed mid-operation with junk data.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit inject);
      int n;
      int busy_cnt;
      @(negedge clk);
      start = 1'b1; op = o; rs = a; rt = b;
      @(negedge clk);                      // E0 has passed
      start = 1'b0; rs = 32'hDEAD_BEEF; rt = 32'h0BAD_F00D;
      n = 0;
      busy_cnt = 0;
      while (!done && n < 50) begin
         if (busy) busy_cnt++;
         if (inject && n == 5) begin
            start = 1'b1; op = 2'b01; hi_we = 1'b1; lo_we = 1'b1; rs = 32'hAAAA_0000;
         end
         if (inject && n == 6) begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, 32'(n), 32'd33);
      check({name, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
      check({name, " hi"}, hi, exp_hi);
      check({name, " lo"}, lo, exp_lo);
      @(negedge clk);
      check({name, " done_pulse_end"}, {31'b0, done}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [31:0] mh, ml;
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int          seen_done;

      rst = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0; hi_we = 1'b0; lo_we = 1'b0;

      vecs.push_back('{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{"mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      vecs.push_back('{"mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{"divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14});
      vecs.push_back('{"div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{"div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD});
      vecs.push_back('{"div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
      vecs.push_back('{"div_by0", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF});
      vecs.push_back('{"div_neg_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
      vecs.push_back('{"divu_max_by0", 2'b11, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{"divu_big", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF});

      // Reset state
      #12;
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);

      // Junk Start/HiWe/LoWe while busy: original result must land
      run_op("inject_busy", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

      // MTHI / MTLO in idle, separately and together
      @(negedge clk); hi_we = 1'b1; rs = 32'hAAAA_0000;
      @(negedge clk); hi_we = 1'b0;
      check("mthi hi", hi, 32'hAAAA_0000);
      check("mthi lo_kept", lo, 32'd14);
      lo_we = 1'b1; rs = 32'h0000_5555;
      @(negedge clk); lo_we = 1'b0;
      check("mtlo lo", lo, 32'h0000_5555);
      check("mtlo hi_kept", hi, 32'hAAAA_0000);
      hi_we = 1'b1; lo_we = 1'b1; rs = 32'h1357_9BDF;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      check("mthilo hi", hi, 32'h1357_9BDF);
      check("mthilo lo", lo, 32'h1357_9BDF);

      // Start on the same edge as HiWe/LoWe: the writes are dropped
      start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd3;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check("start_prio hi", hi, 32'h1357_9BDF);
      check("start_prio lo", lo, 32'h1357_9BDF);
      check("start_prio busy", {31'b0, busy}, 32'd1);
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) seen_done++;
         @(negedge clk);
      end
      check("start_prio done_seen", 32'(seen_done), 32'd1);
      check("start_prio lo_result", lo, 32'd27);
      check("start_prio hi_result", hi, 32'd0);

      // Reset in the middle of an operation
      @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; rs = 32'h7777_7777;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      start = 1'b1; op = 2'b01; rs = 32'd5; rt = 32'd6;
      @(negedge clk); start = 1'b0;          // E0 passed
      repeat (9) @(negedge clk);             // just past E9
      @(posedge clk); #2;                    // just past E10
      rst = 1'b1;
      #1;
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      check("midreset busy", {31'b0, busy}, 32'd0);
      @(negedge clk); rst = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) seen_done++;
         @(negedge clk);
      end
      check("midreset no_done", 32'(seen_done), 32'd0);
      run_op("after_reset", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = -32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
         model(ro, ra, rb, mh, ml);
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, mh, ml, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
